// File: rtl/i2c_cond_detector.sv
// i2c_cond_detector
//
// Front-end condition detector for an I2C bus. The raw SDA/SCL pins are
// synchronised, glitch filtered, and then decoded into registered
// single-cycle pulses (START, repeated START, STOP, SCL rise, SCL fall).
// A two-state busy tracker and a per-byte bit counter flag the byte
// boundary and the ACK slot, together with the sampled ACK value.
//
// Parameters
//   SYNC_STAGES : synchroniser depth per line (2..4)
//   FILTER_LEN  : consecutive differing samples needed to move a filtered
//                 line (1..15)
//
// Ports
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   sda_in        : raw SDA pin (asynchronous)
//   scl_in        : raw SCL pin (asynchronous)
//   sda_flt_out   : filtered SDA level
//   scl_flt_out   : filtered SCL level
//   start_out     : pulse, START seen while bus idle
//   rstart_out    : pulse, START seen while bus busy (repeated START)
//   stop_out      : pulse, STOP condition
//   scl_rise_out  : pulse, filtered SCL 0->1
//   scl_fall_out  : pulse, filtered SCL 1->0
//   bus_busy_out  : high from START until STOP
//   bit_cnt_out   : SCL rises counted in the current byte frame (0..8)
//   byte_done_out : pulse on the 8th SCL rise of a frame
//   ack_slot_out  : pulse on the 9th SCL rise of a frame
//   ack_out       : ACK value sampled in the last ACK slot (1 = SDA low)

module i2c_cond_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_flt_out,
  output logic       scl_flt_out,
  output logic       start_out,
  output logic       rstart_out,
  output logic       stop_out,
  output logic       scl_rise_out,
  output logic       scl_fall_out,
  output logic       bus_busy_out,
  output logic [3:0] bit_cnt_out,
  output logic       byte_done_out,
  output logic       ack_slot_out,
  output logic       ack_out
);

  localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sda_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic                   sda_s;
  logic                   scl_s;

  logic [CNT_W-1:0]       sda_cnt;
  logic [CNT_W-1:0]       scl_cnt;
  logic                   sda_flt;
  logic                   scl_flt;
  logic                   sda_prev;
  logic                   scl_prev;

  logic                   scl_held;
  logic                   start_cond;
  logic                   stop_cond;
  logic                   rise_cond;
  logic                   fall_cond;

  state_t                 state;
  state_t                 state_nxt;
  logic                   start_nxt;
  logic                   rstart_nxt;
  logic                   stop_nxt;

  logic [3:0]             bit_cnt_nxt;
  logic                   byte_done_nxt;
  logic                   ack_slot_nxt;
  logic                   ack_nxt;

  // Synchronisers reset to 1 so a reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_sync <= '1;
      scl_sync <= '1;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
    end
  end

  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];

  // Glitch filters: a line only moves after FILTER_LEN consecutive
  // synchronised samples that disagree with it; the update happens on
  // the same edge that the count would reach FILTER_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_cnt  <= '0;
      scl_cnt  <= '0;
      sda_flt  <= 1'b1;
      scl_flt  <= 1'b1;
      sda_prev <= 1'b1;
      scl_prev <= 1'b1;
    end else begin
      sda_prev <= sda_flt;
      scl_prev <= scl_flt;

      if (sda_s != sda_flt) begin
        if (sda_cnt == CNT_LAST) begin
          sda_flt <= sda_s;
          sda_cnt <= '0;
        end else begin
          sda_cnt <= sda_cnt + 1'b1;
        end
      end else begin
        sda_cnt <= '0;
      end

      if (scl_s != scl_flt) begin
        if (scl_cnt == CNT_LAST) begin
          scl_flt <= scl_s;
          scl_cnt <= '0;
        end else begin
          scl_cnt <= scl_cnt + 1'b1;
        end
      end else begin
        scl_cnt <= '0;
      end
    end
  end

  assign sda_flt_out = sda_flt;
  assign scl_flt_out = scl_flt;

  // START/STOP need SCL high on both samples, so an SDA edge coinciding
  // with an SCL edge is never decoded as a bus condition.
  assign scl_held   = scl_prev & scl_flt;
  assign start_cond = scl_held & sda_prev & ~sda_flt;
  assign stop_cond  = scl_held & ~sda_prev & sda_flt;
  assign rise_cond  = scl_flt & ~scl_prev;
  assign fall_cond  = ~scl_flt & scl_prev;

  always_comb begin
    state_nxt  = state;
    start_nxt  = 1'b0;
    rstart_nxt = 1'b0;
    stop_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start_cond) begin
          state_nxt = BUSY;
          start_nxt = 1'b1;
        end else if (stop_cond) begin
          stop_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (start_cond) begin
          rstart_nxt = 1'b1;
        end else if (stop_cond) begin
          state_nxt = IDLE;
          stop_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter: 8 data rises then the ACK rise, which wraps the count.
  always_comb begin
    bit_cnt_nxt   = bit_cnt_out;
    byte_done_nxt = 1'b0;
    ack_slot_nxt  = 1'b0;
    ack_nxt       = ack_out;
    if (start_cond || stop_cond) begin
      bit_cnt_nxt = 4'd0;
    end else if (rise_cond && (state == BUSY)) begin
      if (bit_cnt_out == 4'd8) begin
        bit_cnt_nxt  = 4'd0;
        ack_slot_nxt = 1'b1;
        ack_nxt      = ~sda_flt;
      end else begin
        bit_cnt_nxt   = bit_cnt_out + 4'd1;
        byte_done_nxt = (bit_cnt_out == 4'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_out     <= 1'b0;
      rstart_out    <= 1'b0;
      stop_out      <= 1'b0;
      scl_rise_out  <= 1'b0;
      scl_fall_out  <= 1'b0;
      bus_busy_out  <= 1'b0;
      bit_cnt_out   <= 4'd0;
      byte_done_out <= 1'b0;
      ack_slot_out  <= 1'b0;
      ack_out       <= 1'b0;
    end else begin
      state         <= state_nxt;
      start_out     <= start_nxt;
      rstart_out    <= rstart_nxt;
      stop_out      <= stop_nxt;
      scl_rise_out  <= rise_cond;
      scl_fall_out  <= fall_cond;
      bus_busy_out  <= (state_nxt == BUSY);
      bit_cnt_out   <= bit_cnt_nxt;
      byte_done_out <= byte_done_nxt;
      ack_slot_out  <= ack_slot_nxt;
      ack_out       <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_cond_detector.sv
// tb_i2c_cond_detector
//
// Self-checking bench for i2c_cond_detector with default parameters.
// A reference model built from pin-sample delay queues and filter sample
// histories predicts every output each cycle; a table of bus phases,
// hand-written byte/ACK, glitch and reset sequences, and a random pin
// stream drive the design.

module tb_i2c_cond_detector;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sda_in = 1'b1;
  logic       scl_in = 1'b1;
  logic       sda_flt_out;
  logic       scl_flt_out;
  logic       start_out;
  logic       rstart_out;
  logic       stop_out;
  logic       scl_rise_out;
  logic       scl_fall_out;
  logic       bus_busy_out;
  logic [3:0] bit_cnt_out;
  logic       byte_done_out;
  logic       ack_slot_out;
  logic       ack_out;

  always #5 clk = ~clk;

  i2c_cond_detector #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sda_in       (sda_in),
    .scl_in       (scl_in),
    .sda_flt_out  (sda_flt_out),
    .scl_flt_out  (scl_flt_out),
    .start_out    (start_out),
    .rstart_out   (rstart_out),
    .stop_out     (stop_out),
    .scl_rise_out (scl_rise_out),
    .scl_fall_out (scl_fall_out),
    .bus_busy_out (bus_busy_out),
    .bit_cnt_out  (bit_cnt_out),
    .byte_done_out(byte_done_out),
    .ack_slot_out (ack_slot_out),
    .ack_out      (ack_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Tallies of pulses observed on the DUT since the last clear.
  int seen_start, seen_rstart, seen_stop, seen_rise, seen_fall;
  int seen_byte, seen_ack, seen_sda_low;
  int last_ack;

  // Reference model state.
  bit syn_sda[$];
  bit syn_scl[$];
  bit hist_sda[$];
  bit hist_scl[$];
  bit m_sda, m_scl, m_sda_prev, m_scl_prev, m_busy, m_ack;
  int m_cnt;
  bit e_start, e_rstart, e_stop, e_rise, e_fall, e_byte, e_ack_slot;

  typedef struct {
    bit sda;
    bit scl;
    int n_start;
    int n_rstart;
    int n_stop;
    int n_rise;
    int n_fall;
    bit busy;
    int cnt;
  } phase_t;

  phase_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit all_equal(input bit q[$], input bit v);
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    syn_sda.delete();
    syn_scl.delete();
    hist_sda.delete();
    hist_scl.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      syn_sda.push_back(1'b1);
      syn_scl.push_back(1'b1);
    end
    for (int i = 0; i < FILTER_LEN; i++) begin
      hist_sda.push_back(1'b1);
      hist_scl.push_back(1'b1);
    end
    m_sda = 1; m_scl = 1; m_sda_prev = 1; m_scl_prev = 1;
    m_busy = 0; m_ack = 0; m_cnt = 0;
    e_start = 0; e_rstart = 0; e_stop = 0; e_rise = 0; e_fall = 0;
    e_byte = 0; e_ack_slot = 0;
  endtask

  // One clock edge of the bus model, with the pin values sampled there.
  task automatic modelAdvance(input bit p_sda, input bit p_scl);
    bit scl_held, start_c, stop_c;
    scl_held   = m_scl & m_scl_prev;
    start_c    = scl_held & m_sda_prev & !m_sda;
    stop_c     = scl_held & !m_sda_prev & m_sda;
    e_rise     = m_scl & !m_scl_prev;
    e_fall     = !m_scl & m_scl_prev;
    e_start    = start_c & !m_busy;
    e_rstart   = start_c & m_busy;
    e_stop     = stop_c;
    e_byte     = 0;
    e_ack_slot = 0;
    if (start_c) begin
      m_busy = 1; m_cnt = 0;
    end else if (stop_c) begin
      m_busy = 0; m_cnt = 0;
    end else if (e_rise && m_busy) begin
      m_cnt++;
      if (m_cnt == 8) e_byte = 1;
      if (m_cnt == 9) begin
        e_ack_slot = 1;
        m_ack      = !m_sda;
        m_cnt      = 0;
      end
    end
    m_sda_prev = m_sda;
    m_scl_prev = m_scl;
    hist_sda.push_back(syn_sda[0]);
    void'(hist_sda.pop_front());
    hist_scl.push_back(syn_scl[0]);
    void'(hist_scl.pop_front());
    if (all_equal(hist_sda, !m_sda)) m_sda = !m_sda;
    if (all_equal(hist_scl, !m_scl)) m_scl = !m_scl;
    syn_sda.push_back(p_sda);
    void'(syn_sda.pop_front());
    syn_scl.push_back(p_scl);
    void'(syn_scl.pop_front());
  endtask

  task automatic checkOutput();
    chk("sda_flt",   sda_flt_out,   m_sda);
    chk("scl_flt",   scl_flt_out,   m_scl);
    chk("start",     start_out,     e_start);
    chk("rstart",    rstart_out,    e_rstart);
    chk("stop",      stop_out,      e_stop);
    chk("scl_rise",  scl_rise_out,  e_rise);
    chk("scl_fall",  scl_fall_out,  e_fall);
    chk("bus_busy",  bus_busy_out,  m_busy);
    chk("bit_cnt",   bit_cnt_out,   m_cnt[3:0]);
    chk("byte_done", byte_done_out, e_byte);
    chk("ack_slot",  ack_slot_out,  e_ack_slot);
    chk("ack",       ack_out,       m_ack);
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_sda_flt"},   sda_flt_out,   1);
    chk({tag, "_scl_flt"},   scl_flt_out,   1);
    chk({tag, "_start"},     start_out,     0);
    chk({tag, "_rstart"},    rstart_out,    0);
    chk({tag, "_stop"},      stop_out,      0);
    chk({tag, "_rise"},      scl_rise_out,  0);
    chk({tag, "_fall"},      scl_fall_out,  0);
    chk({tag, "_busy"},      bus_busy_out,  0);
    chk({tag, "_bit_cnt"},   bit_cnt_out,   0);
    chk({tag, "_byte_done"}, byte_done_out, 0);
    chk({tag, "_ack_slot"},  ack_slot_out,  0);
    chk({tag, "_ack"},       ack_out,       0);
  endtask

  task automatic clearTally();
    seen_start = 0; seen_rstart = 0; seen_stop = 0; seen_rise = 0;
    seen_fall = 0; seen_byte = 0; seen_ack = 0; seen_sda_low = 0;
  endtask

  task automatic applyStimulus(input bit sda, input bit scl);
    @(negedge clk);
    sda_in = sda;
    scl_in = scl;
    @(posedge clk);
    #1;
    modelAdvance(sda, scl);
    checkOutput();
    seen_start   += int'(start_out);
    seen_rstart  += int'(rstart_out);
    seen_stop    += int'(stop_out);
    seen_rise    += int'(scl_rise_out);
    seen_fall    += int'(scl_fall_out);
    seen_byte    += int'(byte_done_out);
    seen_sda_low += int'(!sda_flt_out);
    if (ack_slot_out) begin
      seen_ack++;
      last_ack = int'(ack_out);
    end
  endtask

  task automatic applyN(input bit sda, input bit scl, input int n);
    repeat (n) applyStimulus(sda, scl);
  endtask

  // Data changes only while SCL is low.
  task automatic sendBit(input bit b);
    applyN(b, 1'b0, 6);
    applyN(b, 1'b1, 6);
    applyN(b, 1'b0, 6);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] data;
    int         lat;

    // sda scl start rstart stop rise fall busy cnt
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 1, 0, 1, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 1, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 2};
    tbl[10] = '{1, 1, 0, 0, 0, 1, 0, 1, 3};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
    tbl[14] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[20] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[22] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};

    last_ack = -1;
    clearTally();
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    releaseReset();

    // Bus phases, each held long enough for its pulses to appear.
    for (int i = 0; i < 23; i++) begin
      clearTally();
      applyN(tbl[i].sda, tbl[i].scl, 8);
      chk($sformatf("tbl%0d_start", i),   seen_start,   tbl[i].n_start);
      chk($sformatf("tbl%0d_rstart", i),  seen_rstart,  tbl[i].n_rstart);
      chk($sformatf("tbl%0d_stop", i),    seen_stop,    tbl[i].n_stop);
      chk($sformatf("tbl%0d_rise", i),    seen_rise,    tbl[i].n_rise);
      chk($sformatf("tbl%0d_fall", i),    seen_fall,    tbl[i].n_fall);
      chk($sformatf("tbl%0d_busy", i),    bus_busy_out, tbl[i].busy);
      chk($sformatf("tbl%0d_cnt", i),     bit_cnt_out,  tbl[i].cnt);
      chk($sformatf("tbl%0d_sda_flt", i), sda_flt_out,  tbl[i].sda);
      chk($sformatf("tbl%0d_scl_flt", i), scl_flt_out,  tbl[i].scl);
    end

    // START latency from the first sampling edge of the SDA fall.
    clearTally();
    lat = -1;
    applyStimulus(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1);
      if (start_out) begin
        lat = k;
        break;
      end
    end
    chk("start_latency", lat, 5);
    chk("busy_at_start", bus_busy_out, 1);
    applyN(1'b0, 1'b1, 4);
    chk("busy_after_start", bus_busy_out, 1);
    chk("single_start", seen_start, 1);

    // Byte 0xA5 acknowledged, then byte 0x3C not acknowledged.
    applyN(1'b0, 1'b0, 6);
    for (int pass = 0; pass < 2; pass++) begin
      clearTally();
      data = (pass == 0) ? 8'hA5 : 8'h3C;
      for (int b = 7; b >= 0; b--) sendBit(data[b]);
      chk($sformatf("byte%0d_done", pass), seen_byte, 1);
      chk($sformatf("byte%0d_cnt8", pass), bit_cnt_out, 8);
      chk($sformatf("byte%0d_no_ack_yet", pass), seen_ack, 0);
      sendBit(pass == 1);
      chk($sformatf("byte%0d_ack_slot", pass), seen_ack, 1);
      chk($sformatf("byte%0d_ack_val", pass), last_ack, (pass == 0) ? 1 : 0);
      chk($sformatf("byte%0d_ack_out", pass), ack_out, (pass == 0) ? 1 : 0);
      chk($sformatf("byte%0d_cnt0", pass), bit_cnt_out, 0);
    end

    // STOP, then SCL activity while idle must not count.
    clearTally();
    applyN(1'b0, 1'b0, 6);
    applyN(1'b0, 1'b1, 6);
    applyN(1'b1, 1'b1, 8);
    chk("stop_seen", seen_stop, 1);
    chk("idle_after_stop", bus_busy_out, 0);
    applyN(1'b1, 1'b0, 6);
    applyN(1'b1, 1'b1, 6);
    chk("idle_rise_no_count", bit_cnt_out, 0);

    // Two-cycle SDA glitch is swallowed, three-cycle low gets through.
    clearTally();
    applyN(1'b0, 1'b1, 2);
    applyN(1'b1, 1'b1, 10);
    chk("glitch_sda_flt_low", seen_sda_low, 0);
    chk("glitch_no_start", seen_start, 0);
    clearTally();
    applyN(1'b0, 1'b1, 3);
    applyN(1'b1, 1'b1, 10);
    chk("pulse3_start", seen_start, 1);
    chk("pulse3_stop", seen_stop, 1);

    // Asynchronous reset in the middle of a byte.
    applyN(1'b0, 1'b1, 8);
    applyN(1'b0, 1'b0, 6);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    chk("pre_reset_cnt", bit_cnt_out, 3);
    chk("pre_reset_busy", bus_busy_out, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async");
    sda_in = 1'b1;
    scl_in = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    releaseReset();
    clearTally();
    applyN(1'b1, 1'b1, 10);
    chk("post_reset_no_start", seen_start, 0);
    chk("post_reset_no_stop", seen_stop, 0);
    chk("post_reset_no_edge", seen_rise + seen_fall, 0);

    // Random pin activity, including short glitches, against the model.
    for (int i = 0; i < 300; i++) begin
      applyN(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(1, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_cond_detector.md
# i2c_cond_detector

Parametrised I2C bus-condition detector for the filter datapath front end. It takes the asynchronous SDA/SCL pins through a configurable synchroniser and a per-line glitch filter. From the filtered lines it produces registered single-cycle pulses for START, repeated START, STOP, SCL rise and SCL fall. It also tracks bus-busy state and counts bits within each byte, flagging the byte boundary and the ACK slot with the sampled ACK value.

## Interface
- SYNC_STAGES, 2: synchroniser depth per line; legal range 2..4.
- FILTER_LEN, 3: consecutive differing synchronised samples required before a filtered line changes; legal range 1..15.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sda_in  input  1  raw SDA pin, asynchronous to clk.
- scl_in  input  1  raw SCL pin, asynchronous to clk.
- sda_flt_out  output  1  filtered SDA level.
- scl_flt_out  output  1  filtered SCL level.
- start_out  output  1  pulse: START while bus idle.
- rstart_out  output  1  pulse: START while bus busy (repeated START).
- stop_out  output  1  pulse: STOP condition.
- scl_rise_out  output  1  pulse: filtered SCL 0->1.
- scl_fall_out  output  1  pulse: filtered SCL 1->0.
- bus_busy_out  output  1  high from START to STOP.
- bit_cnt_out  output  4  SCL rises counted in the current byte frame, 0..8.
- byte_done_out  output  1  pulse on the 8th SCL rise of a frame.
- ack_slot_out  output  1  pulse on the 9th SCL rise of a frame.
- ack_out  output  1  valid with ack_slot_out; 1 = ACK (filtered SDA low at the rise).

## Operation
- One clock; reset is asynchronous and active-low: clock port is clk, reset port is rst_n, and the polarity and synchronicity are fixed.
- Reset values:
  - All synchroniser flops, filtered lines and past-value flops reset to 1 (idle bus).
  - sda_flt_out = scl_flt_out = 1.
  - bit_cnt_out = 0.
  - Every pulse output, bus_busy_out and ack_out reset to 0.
- Synchroniser: SYNC_STAGES flops per line; its output is the synchronised value.
- Glitch filter, per line:
  - Counter of width $clog2(FILTER_LEN+1).
  - While synchronised value != filtered value, the counter increments; when it reaches FILTER_LEN, the filtered value takes the synchronised value and the counter clears.
  - Any cycle with synchronised value == filtered value clears the counter.
  - A synchronised glitch shorter than FILTER_LEN cycles never reaches the filtered line.
- Condition decode, from filtered (s, l) and previous-cycle filtered (ps, pl) values:
  - Start condition: pl & l & ps & !s.
  - Stop condition: pl & l & !ps & s.
  - Rise: l & !pl.
  - Fall: !l & pl.
  - If SDA and SCL change in the same cycle, no START or STOP is decoded. Edges are still reported.
- Busy state machine, states IDLE and BUSY:
  - IDLE + start -> BUSY, with start_out.
  - BUSY + start -> BUSY, with rstart_out.
  - BUSY + stop -> IDLE, with stop_out.
  - IDLE + stop -> IDLE, with stop_out.
  - start_out and rstart_out are mutually exclusive.
- Bit counter:
  - Cleared to 0 on start, repeated start or stop.
  - Increments only on a rise while in BUSY; rises in IDLE are ignored.
  - Rise taking the count 7->8: byte_done_out.
  - Rise at count 8: ack_slot_out, ack_out = !filtered SDA, count wraps to 0.
  - ack_out holds its value until the next ACK slot.

## Timing
- A pin level first sampled at edge N appears on the filtered line after edge N+SYNC_STAGES+FILTER_LEN-1. The corresponding pulses appear after edge N+SYNC_STAGES+FILTER_LEN: 5 cycles with defaults.
- All outputs are registered. Pulses last exactly one cycle.
- bus_busy_out and bit_cnt_out update in the same cycle as their causing pulse.
- Reset assertion mid-transfer immediately forces all outputs and the state machine to reset values. After release the bus is treated as IDLE, and no spurious pulse is produced while the pins are high.

## Test plan
- Default parameters. SDA falls while SCL is held high. Required: start_out for one cycle 5 cycles later, and bus_busy_out = 1 from that cycle on.
- While BUSY, issue a second START. Required: rstart_out pulses, start_out stays 0, and bit_cnt_out returns to 0.
- Send 8 data bits, then a 9th clock with SDA = 0. Required: byte_done_out on the 8th rise, then ack_slot_out with ack_out = 1 on the 9th rise, and bit_cnt_out back to 0. Repeat with SDA = 1 on the 9th clock and require ack_out = 0.
- FILTER_LEN = 3. Apply a 2-cycle SDA low glitch with SCL high. Required: sda_flt_out stays 1 and no START. A 3-cycle low produces a START.
- Toggle SDA and SCL in the same cycle (both falling). Required: scl_fall_out pulses and there is no START or STOP.
- After a STOP, bus_busy_out = 0 and SCL rises do not change bit_cnt_out. Assert rst_n low in the middle of a byte. Required: outputs return to reset values asynchronously.
